nibble_serial_adder: RTL and testbench
======================================

Name: nibble_serial_adder

Overview:
Sequencer that computes wide add/subtract results with a single 4-bit nibble adder stage. The stage uses 5-bit internal arithmetic: a 4-bit sum plus a carry-out bit. The block iterates over the nibbles, LSB first, and chains the carry between them. It sits between a requester using a start/busy/done handshake and wider datapath consumers, trading latency for area.

Parameters:
NIBBLES, 4, number of 4-bit nibbles per operand; operand width W = 4*NIBBLES; legal range 1..16.

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  reset, asynchronous assert, active-low
start  input  1  request; accepted only when busy=0
sub  input  1  0: A+B; 1: A-B (A + ~B + 1); sampled with start
in_data1  input  W  operand A; sampled with start
in_data2  input  W  operand B; sampled with start
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when the result is valid
out_data  output  W  result; stable between done pulses
cy  output  1  final carry-out; for sub, 1 = no borrow
ovf  output  1  signed two's-complement overflow of the final result

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset state: state=IDLE; busy=0, done=0, out_data=0, cy=0, ovf=0; internal registers cleared.
- State IDLE:
  - start=1 latches A, B (inverted when sub=1) and sub.
  - Sets carry=sub and idx=0, then goes to RUN.
  - busy=1 from the next cycle.
- State RUN, one nibble per cycle:
  - nib = A[idx] + B'[idx] + carry, computed at 5-bit width.
  - work[idx] <= nib[3:0]; carry <= nib[4].
  - On the top nibble only, also capture the carry into bit 3 (c3) for overflow.
  - idx <= idx+1. When idx==NIBBLES-1, go to DONE.
- State DONE, lasts one cycle:
  - done=1, busy=0.
  - out_data <= work, cy <= carry, ovf <= c3 XOR carry. These update on entry to DONE and hold until the next DONE.
  - start=1 here is accepted exactly as in IDLE (back-to-back operation); otherwise go to IDLE.
- Latency: start sampled at edge T → done high during cycle T+NIBBLES+1. Throughput is one operation per NIBBLES+1 cycles.
- start while busy=1 is ignored; operands and sub are not re-sampled.
- out_data, cy and ovf never show partial results. The work register is internal only.
- Arithmetic is modulo 2^W. cy is the carry out of bit W-1. Subtraction carry-in is 1, inverted operand B.
- NIBBLES=1: RUN lasts one cycle; c3 and the final carry come from the same nibble.
- Reset asserted mid-RUN: aborts immediately to the reset state. No done pulse, and previous outputs are cleared to 0.
- Reset deassertion: synchronous to the design's reset synchronizer upstream. The first start is accepted on the first rising edge with rst_n=1.
- idx width: clog2(NIBBLES), minimum 1 bit. It never exceeds NIBBLES-1.

Test Plan:
- NIBBLES=4, sub=0, A=0x1234, B=0x4321, start at T → busy=1 for T+1..T+4; done pulse at T+5; out_data=0x5555, cy=0, ovf=0.
- A=0xFFFF, B=0x0001, sub=0 → out_data=0x0000, cy=1, ovf=0. A=0x7FFF, B=0x0001 → out_data=0x8000, cy=0, ovf=1.
- sub=1, A=0x0005, B=0x0007 → out_data=0xFFFE, cy=0 (borrow), ovf=0. sub=1, A=0x8000, B=0x0001 → out_data=0x7FFF, cy=1, ovf=1.
- start pulsed with A=0x1111 during busy (mid-op 0x0001+0x0002) → ignored; result 0x0003. Then start held in the DONE cycle → new op accepted; the next done arrives 5 cycles later.
- rst_n pulled low at T+2 of an operation → outputs 0 immediately, no done, busy=0. The next op after release completes normally.
- NIBBLES=1, A=0x9, B=0x8 → done at T+2, out_data=0x1, cy=1, ovf=1.

Source files
------------

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: W-bit add/subtract computed one 4-bit nibble per cycle,
// LSB first, with the carry chained between nibbles. The requester uses a
// start/busy/done handshake. Results appear only when an operation completes.
module nibble_serial_adder #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   sub,
   input  logic [4*NIBBLES-1:0]   in_data1,
   input  logic [4*NIBBLES-1:0]   in_data2,
   output logic                   busy,
   output logic                   done,
   output logic [4*NIBBLES-1:0]   out_data,
   output logic                   cy,
   output logic                   ovf
);

   localparam int W     = 4 * NIBBLES;
   localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [W-1:0]       a_q, a_d;
   logic [W-1:0]       b_q, b_d;        // already inverted for subtraction
   logic [W-1:0]       work_q, work_d;
   logic               carry_q, carry_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [W-1:0]       out_q, out_d;
   logic               cy_q, cy_d;
   logic               ovf_q, ovf_d;

   logic               accept;
   logic               last;
   logic [3:0]         nib_a, nib_b;
   logic [4:0]         nib;
   logic [3:0]         low3;            // bit 3 is the carry into the nibble's MSB

   // A new request is taken whenever no operation is in flight (IDLE or DONE)
   assign accept = start && (state_q != S_RUN);
   assign last   = (idx_q == IDX_W'(NIBBLES - 1));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic: RUN covers NIBBLES cycles, DONE lasts one cycle
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_RUN;
         S_RUN:   if (last)  state_d = S_DONE;
         S_DONE:  state_d = start ? S_RUN : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Handshake outputs decoded from state
   always_comb begin
      busy = (state_q == S_RUN);
      done = (state_q == S_DONE);
   end

   // Nibble select, 5-bit nibble add and operand/result bookkeeping
   always_comb begin
      nib_a = '0;
      nib_b = '0;
      for (int i = 0; i < NIBBLES; i++) begin
         if (idx_q == IDX_W'(i)) begin
            nib_a = a_q[4*i +: 4];
            nib_b = b_q[4*i +: 4];
         end
      end
      nib  = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0, carry_q};
      low3 = {1'b0, nib_a[2:0]} + {1'b0, nib_b[2:0]} + {3'b0, carry_q};

      a_d     = a_q;
      b_d     = b_q;
      work_d  = work_q;
      carry_d = carry_q;
      idx_d   = idx_q;
      out_d   = out_q;
      cy_d    = cy_q;
      ovf_d   = ovf_q;

      if (accept) begin
         a_d     = in_data1;
         b_d     = sub ? ~in_data2 : in_data2;
         carry_d = sub;
         idx_d   = '0;
      end else if (state_q == S_RUN) begin
         for (int i = 0; i < NIBBLES; i++) begin
            if (idx_q == IDX_W'(i)) work_d[4*i +: 4] = nib[3:0];
         end
         carry_d = nib[4];
         if (last) begin
            // Publish on entry to DONE; the top nibble is folded in directly
            out_d = work_d;
            cy_d  = nib[4];
            ovf_d = low3[3] ^ nib[4];
         end else begin
            idx_d = idx_q + IDX_W'(1);
         end
      end
   end

   // Datapath registers, all cleared by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         work_q  <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         out_q   <= '0;
         cy_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         a_q     <= a_d;
         b_q     <= b_d;
         work_q  <= work_d;
         carry_q <= carry_d;
         idx_q   <= idx_d;
         out_q   <= out_d;
         cy_q    <= cy_d;
         ovf_q   <= ovf_d;
      end
   end

   assign out_data = out_q;
   assign cy       = cy_q;
   assign ovf      = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Testbench for nibble_serial_adder: a 4-nibble instance exercised with
// directed and random operations, plus a 1-nibble instance for the
// single-nibble corner. Expected results come from a wide-arithmetic model.
module tb_nibble_serial_adder;

   localparam int N = 4;
   localparam int W = 4 * N;

   logic          clk;
   logic          rst_n;
   logic          start, sub;
   logic [W-1:0]  in_data1, in_data2;
   logic          busy, done, cy, ovf;
   logic [W-1:0]  out_data;

   logic          start1, sub1;
   logic [3:0]    in1_a, in1_b;
   logic          busy1, done1, cy1, ovf1;
   logic [3:0]    out1;

   int            checks;
   int            errors;

   logic [W-1:0]  prev_out;
   logic          prev_cy, prev_ovf;

   nibble_serial_adder #(.NIBBLES(N)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .sub(sub),
      .in_data1(in_data1), .in_data2(in_data2),
      .busy(busy), .done(done), .out_data(out_data), .cy(cy), .ovf(ovf)
   );

   nibble_serial_adder #(.NIBBLES(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1),
      .in_data1(in1_a), .in_data2(in1_b),
      .busy(busy1), .done(done1), .out_data(out1), .cy(cy1), .ovf(ovf1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: plain w-bit two's-complement add/subtract. Returns {ovf, cy, result}.
   function automatic logic [17:0] ref_op(input logic [15:0] a, input logic [15:0] b,
                                          input logic s, input int w);
      logic [16:0] sum;
      logic [15:0] mask, am, bm, res;
      logic        c, o;
      mask = (w == 16) ? 16'hFFFF : ((16'h1 << w) - 16'h1);
      am   = a & mask;
      bm   = b & mask;
      sum  = {1'b0, am} + {1'b0, (s ? ~bm : bm) & mask} + {16'b0, s};
      c    = sum[w];
      res  = sum[15:0] & mask;
      if (s) o = (am[w-1] != bm[w-1]) && (res[w-1] != am[w-1]);
      else   o = (am[w-1] == bm[w-1]) && (res[w-1] != am[w-1]);
      return {o, c, res};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a request; returns just after the accepting edge with start dropped
   task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      start    = 1'b1;
      in_data1 = a;
      in_data2 = b;
      sub      = s;
      tick();
      start    = 1'b0;
      in_data1 = W'($urandom);
      in_data2 = W'($urandom);
      sub      = 1'($urandom);
   endtask

   // Walk the busy window (skip edges already consumed) and check the DONE cycle
   task automatic finish_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic s, input int skip);
      logic [17:0] e;
      e = ref_op(a, b, s, W);
      for (int k = skip; k < N; k++) begin
         chk("busy_run", {31'b0, busy}, 32'd1);
         chk("done_run", {31'b0, done}, 32'd0);
         chk("out_hold_run", {16'b0, out_data}, {16'b0, prev_out});
         tick();
      end
      chk("done_pulse", {31'b0, done}, 32'd1);
      chk("busy_done", {31'b0, busy}, 32'd0);
      chk("out_data", {16'b0, out_data}, {16'b0, e[15:0]});
      chk("cy", {31'b0, cy}, {31'b0, e[16]});
      chk("ovf", {31'b0, ovf}, {31'b0, e[17]});
      prev_out = e[15:0];
      prev_cy  = e[16];
      prev_ovf = e[17];
   endtask

   task automatic idle_check();
      tick();
      chk("done_idle", {31'b0, done}, 32'd0);
      chk("busy_idle", {31'b0, busy}, 32'd0);
      chk("out_hold_idle", {16'b0, out_data}, {16'b0, prev_out});
      chk("cy_hold_idle", {31'b0, cy}, {31'b0, prev_cy});
      chk("ovf_hold_idle", {31'b0, ovf}, {31'b0, prev_ovf});
   endtask

   task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      launch(a, b, s);
      finish_op(a, b, s, 0);
      idle_check();
   endtask

   task automatic op1(input logic [3:0] a, input logic [3:0] b, input logic s);
      logic [17:0] e;
      e = ref_op({12'b0, a}, {12'b0, b}, s, 4);
      start1 = 1'b1;
      in1_a  = a;
      in1_b  = b;
      sub1   = s;
      tick();
      start1 = 1'b0;
      chk("n1_busy", {31'b0, busy1}, 32'd1);
      chk("n1_done_run", {31'b0, done1}, 32'd0);
      tick();
      chk("n1_done", {31'b0, done1}, 32'd1);
      chk("n1_out", {28'b0, out1}, {28'b0, e[3:0]});
      chk("n1_cy", {31'b0, cy1}, {31'b0, e[16]});
      chk("n1_ovf", {31'b0, ovf1}, {31'b0, e[17]});
      tick();
      chk("n1_done_idle", {31'b0, done1}, 32'd0);
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      prev_out = '0;
      prev_cy  = 1'b0;
      prev_ovf = 1'b0;
      rst_n    = 1'b0;
      start    = 1'b0;
      sub      = 1'b0;
      in_data1 = '0;
      in_data2 = '0;
      start1   = 1'b0;
      sub1     = 1'b0;
      in1_a    = '0;
      in1_b    = '0;

      tick();
      tick();
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_out", {16'b0, out_data}, 32'd0);
      chk("rst_cy", {31'b0, cy}, 32'd0);
      chk("rst_ovf", {31'b0, ovf}, 32'd0);
      rst_n = 1'b1;

      // Directed cases
      op(16'h1234, 16'h4321, 1'b0);
      op(16'hFFFF, 16'h0001, 1'b0);
      op(16'h7FFF, 16'h0001, 1'b0);
      op(16'h0005, 16'h0007, 1'b1);
      op(16'h8000, 16'h0001, 1'b1);

      // start during busy is ignored; start held in DONE is taken back-to-back
      launch(16'h0001, 16'h0002, 1'b0);
      start    = 1'b1;
      in_data1 = 16'h1111;
      in_data2 = 16'h2222;
      sub      = 1'b1;
      tick();
      start    = 1'b0;
      finish_op(16'h0001, 16'h0002, 1'b0, 1);
      launch(16'hA5A5, 16'h1357, 1'b1);
      finish_op(16'hA5A5, 16'h1357, 1'b1, 0);
      idle_check();

      // Reset in the middle of an operation
      launch(16'h1234, 16'h4321, 1'b0);
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", {31'b0, busy}, 32'd0);
      chk("midrst_done", {31'b0, done}, 32'd0);
      chk("midrst_out", {16'b0, out_data}, 32'd0);
      chk("midrst_cy", {31'b0, cy}, 32'd0);
      chk("midrst_ovf", {31'b0, ovf}, 32'd0);
      prev_out = '0;
      prev_cy  = 1'b0;
      prev_ovf = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("midrst_no_done", {31'b0, done}, 32'd0);
      end
      rst_n = 1'b1;
      op(16'h0F0F, 16'h00F1, 1'b0);

      // Random operations, sometimes back-to-back
      for (int i = 0; i < 30; i++) begin
         logic [W-1:0] ra, rb;
         logic         rs;
         ra = W'($urandom);
         rb = W'($urandom);
         rs = 1'($urandom);
         if (i % 7 == 0) ra = 16'h8000 | ra;
         launch(ra, rb, rs);
         finish_op(ra, rb, rs, 0);
         if ($urandom_range(1) == 1) idle_check();
      end
      idle_check();

      // Single-nibble instance
      op1(4'h9, 4'h8, 1'b0);
      op1(4'h7, 4'h1, 1'b0);
      op1(4'h8, 4'h1, 1'b1);
      for (int i = 0; i < 10; i++) begin
         op1(4'($urandom), 4'($urandom), 1'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
